// File: rtl/mux_oper_a.sv
// -----------------------------------------------------------------------------
// mux_oper_a
//
// Operand-A source selector for the ALU input. Picks one of three 32-bit
// sources, or a constant zero, and registers the result so the ALU sees a
// stable operand for the whole cycle following the capture edge.
//
// Ports:
//   clk            in   1   rising-edge clock for the output register
//   rst_n          in   1   asynchronous active-low reset, clears output_A
//   input_number   in  32   register-file operand
//   immediate_ext  in  32   sign/zero-extended immediate from decode
//   immediate_desp in  32   shifted (displacement) immediate from decode
//   sel_operA      in   2   source select: 0 reg, 1 ext imm, 2 disp imm, 3 zero
//   output_A       out 32   registered operand A (1-cycle latency)
// -----------------------------------------------------------------------------
module mux_oper_a (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] input_number,
    input  logic [31:0] immediate_ext,
    input  logic [31:0] immediate_desp,
    input  logic [1:0]  sel_operA,
    output logic [31:0] output_A
);

    // Select encodings as driven by the control unit.
    typedef enum logic [1:0] {
        SEL_REG  = 2'b00,
        SEL_EXT  = 2'b01,
        SEL_DESP = 2'b10,
        SEL_ZERO = 2'b11
    } sel_t;

    logic [31:0] operand_next;

    always_comb begin
        // NOTE: assigning a default before the case guarantees every path
        // drives operand_next, so no latch is inferred. The default branch
        // also sends an X/Z select to zero instead of holding a stale value.
        operand_next = 32'h0000_0000;
        case (sel_operA)
            SEL_REG:  operand_next = input_number;
            SEL_EXT:  operand_next = immediate_ext;
            SEL_DESP: operand_next = immediate_desp;
            SEL_ZERO: operand_next = 32'h0000_0000;
            default:  operand_next = 32'h0000_0000;
        endcase
    end

    // Captured on every edge: no enable, no hold. Reset clears the register
    // immediately and the previous operand is not restored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the pre-edge values of its inputs.
        if (!rst_n) begin
            output_A <= 32'h0000_0000;
        end else begin
            output_A <= operand_next;
        end
    end

endmodule

// File: tb/tb_mux_oper_a.sv
// -----------------------------------------------------------------------------
// tb_mux_oper_a
//
// Self-checking bench for mux_oper_a. Expected values come from a small
// behavioural model: the operand is the indexed entry of the source table,
// or zero for select 3, appearing one rising edge after it is presented.
// -----------------------------------------------------------------------------
module tb_mux_oper_a;

    logic        clk;
    logic        rst_n;
    logic [31:0] input_number;
    logic [31:0] immediate_ext;
    logic [31:0] immediate_desp;
    logic [1:0]  sel_operA;
    logic [31:0] output_A;

    int checks   = 0;
    int failures = 0;

    mux_oper_a dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .input_number   (input_number),
        .immediate_ext  (immediate_ext),
        .immediate_desp (immediate_desp),
        .sel_operA      (sel_operA),
        .output_A       (output_A)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: the three sources form a table indexed by select; the
    // fourth select value is a constant zero.
    function automatic logic [31:0] ref_oper_a(input logic [1:0] s,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] c);
        logic [31:0] table_src [0:2];
        table_src[0] = a;
        table_src[1] = b;
        table_src[2] = c;
        if (s == 2'd3) return 32'd0;
        return table_src[s];
    endfunction

    // Present inputs just after an edge, then check one edge later.
    task automatic step(input string tag, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        sel_operA      = s;
        input_number   = a;
        immediate_ext  = b;
        immediate_desp = c;
        @(posedge clk);
        #1;
        check(tag, output_A, ref_oper_a(s, a, b, c));
    endtask

    initial begin
        logic [31:0] a, b, c, decoy;
        logic [1:0]  s;

        // Reset with nonzero sources and select 1: output clears with no edge.
        rst_n          = 1'b1;
        input_number   = 32'd1807;
        immediate_ext  = 32'd2703;
        immediate_desp = 32'd707;
        sel_operA      = 2'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", output_A, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", output_A, 32'd0);
        end

        // Release away from the edge; first edge with rst_n high loads.
        rst_n = 1'b1;
        step("sel0", 2'd0, 32'd1807, 32'd2703, 32'd707);

        // Latency: select flips mid-cycle, output holds until the next edge.
        #3;
        sel_operA = 2'd2;
        #1;
        check("latency_hold", output_A, 32'd1807);
        @(posedge clk);
        #1;
        check("latency_load", output_A, 32'd707);

        // Sweep selects 1..3.
        step("sweep1", 2'd1, 32'd1807, 32'd2703, 32'd707);
        step("sweep2", 2'd2, 32'd1807, 32'd2703, 32'd707);
        step("sweep3", 2'd3, 32'd1807, 32'd2703, 32'd707);

        // Full-width pass-through with no sign alteration.
        step("width_ones", 2'd1, 32'd1807, 32'hFFFF_FFFF, 32'd707);
        step("width_msb",  2'd1, 32'd1807, 32'h8000_0001, 32'd707);
        step("width_desp", 2'd2, 32'd0,    32'd0,         32'hA5A5_5A5A);

        // Mid-run reset: output clears immediately, returns after release.
        step("pre_reset", 2'd2, 32'd1807, 32'd2703, 32'd707);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset", output_A, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrun_released_noedge", output_A, 32'd0);
        @(posedge clk);
        #1;
        check("midrun_reload", output_A, 32'd707);

        // Randomised traffic; a decoy value is presented mid-cycle and then
        // replaced, so only the final pre-edge values may be captured.
        for (int i = 0; i < 300; i++) begin
            a     = $urandom;
            b     = $urandom;
            c     = $urandom;
            s     = 2'($urandom_range(0, 3));
            decoy = $urandom;
            sel_operA      = 2'($urandom_range(0, 3));
            input_number   = decoy;
            immediate_ext  = ~decoy;
            immediate_desp = decoy ^ 32'h5555_5555;
            #2;
            step("random", s, a, b, c);
            if ((i % 50) == 49) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("random_reset", output_A, 32'd0);
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
